// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse_meter block: measurement FSM encoding and
// default sizing for the 50 MHz board clock.
package pulse_meter_pkg;

    localparam int unsigned CNT_W_DEFAULT   = 27;
    // 2.4 s of silence at 50 MHz before the input is declared lost
    localparam int unsigned TIMEOUT_DEFAULT = 120_000_000;
    localparam int unsigned TICK_CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } meas_state_e;

endpackage

// File: rtl/pulse_meter_sync_edge_detect.sv
// Two-flop synchronizer with a history flop; reports the synchronized level
// and single-cycle rise/fall qualifiers. Reusable for buttons and other pins.
module pulse_meter_sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level_c,
    output logic rise_c,
    output logic fall_c
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 resolve metastability, s3 holds the previous synchronized level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level_c = s2;
    assign rise_c  = s2 & ~s3;
    assign fall_c  = ~s2 & s3;

endmodule

// File: rtl/pulse_meter.sv
// Measures a slow asynchronous square wave: per-edge tick, edge count,
// high time and period in clk cycles, and a sticky loss-of-signal flag.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pulse_in,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic [CNT_W-1:0]      high_cnt,
    output logic [CNT_W-1:0]      period_cnt,
    output logic                  meas_valid,
    output logic                  lost
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic unused_level_c;
    logic rise_c;
    logic fall_c;

    meas_state_e           state;
    meas_state_e           state_nxt;
    logic [CNT_W-1:0]      run_cnt;
    logic [CNT_W-1:0]      run_cnt_nxt;
    logic [CNT_W-1:0]      hi_cap;
    logic [CNT_W-1:0]      hi_cap_nxt;
    logic                  tick_nxt;
    logic [TICK_CNT_W-1:0] tick_count_nxt;
    logic [CNT_W-1:0]      high_cnt_nxt;
    logic [CNT_W-1:0]      period_cnt_nxt;
    logic                  meas_valid_nxt;
    logic                  lost_nxt;

    pulse_meter_sync_edge_detect u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (pulse_in),
        .level_c  (unused_level_c),
        .rise_c   (rise_c),
        .fall_c   (fall_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            run_cnt    <= '0;
            hi_cap     <= '0;
            tick       <= 1'b0;
            tick_count <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            meas_valid <= 1'b0;
            lost       <= 1'b0;
        end else begin
            state      <= state_nxt;
            run_cnt    <= run_cnt_nxt;
            hi_cap     <= hi_cap_nxt;
            tick       <= tick_nxt;
            tick_count <= tick_count_nxt;
            high_cnt   <= high_cnt_nxt;
            period_cnt <= period_cnt_nxt;
            meas_valid <= meas_valid_nxt;
            lost       <= lost_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        run_cnt_nxt    = run_cnt;
        hi_cap_nxt     = hi_cap;
        tick_nxt       = rise_c;
        tick_count_nxt = tick_count;
        high_cnt_nxt   = high_cnt;
        period_cnt_nxt = period_cnt;
        meas_valid_nxt = 1'b0;
        lost_nxt       = lost;

        // run_cnt counts cycles since the last rise and parks at TIMEOUT
        if (rise_c) begin
            run_cnt_nxt    = CNT_W'(1);
            tick_count_nxt = tick_count + TICK_CNT_W'(1);
        end else if (run_cnt != TIMEOUT_C) begin
            run_cnt_nxt = run_cnt + CNT_W'(1);
        end

        // A rise always wins over a coincident timeout
        if (rise_c) begin
            lost_nxt  = 1'b0;
            state_nxt = ST_HIGH;
            if (state == ST_LOW) begin
                period_cnt_nxt = run_cnt;
                high_cnt_nxt   = hi_cap;
                meas_valid_nxt = 1'b1;
            end
        end else if (run_cnt == TIMEOUT_C) begin
            lost_nxt  = 1'b1;
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_HIGH: begin
                    if (fall_c) begin
                        state_nxt  = ST_LOW;
                        hi_cap_nxt = run_cnt;
                    end
                end
                ST_IDLE: state_nxt = ST_IDLE;
                ST_LOW:  state_nxt = ST_LOW;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Scoreboard bench for pulse_meter: the waveform model predicts ticks,
// measurements and loss events from the sampled input; a monitor checks them.
module tb_pulse_meter;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMEOUT = 40;
    localparam int          SYNC_LAT = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             pulse_in = 1'b0;
    logic             tick;
    logic [7:0]       tick_count;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             lost;

    pulse_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pulse_in   (pulse_in),
        .tick       (tick),
        .tick_count (tick_count),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .lost       (lost)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int cnt; } tick_exp_t;
    typedef struct { int cyc; int high; int period; } meas_exp_t;

    tick_exp_t tick_q[$];
    meas_exp_t meas_q[$];
    int        lost_q[$];

    int total  = 0;
    int passed = 0;
    int edge_n = 0;
    bit armed  = 0;
    int tick_seen = 0;
    int held_high = 0;
    int held_period = 0;

    // reference model state, in units of sampling edges since reset
    bit m_prev;
    int m_tcount;
    bit m_have;
    int m_rise;
    int m_fall;
    int m_ref;
    bit m_lost_done;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    endtask

    function automatic void model_reset();
        m_prev = 0; m_tcount = 0; m_have = 0; m_rise = 0; m_fall = 0;
        m_ref = -1; m_lost_done = 0; edge_n = 0;
        held_high = 0; held_period = 0; tick_seen = 0;
        tick_q.delete(); meas_q.delete(); lost_q.delete();
    endfunction

    // Rules: a tick per input rise; period = rise to rise, high = rise to fall;
    // silence of TIMEOUT cycles after a rise (or reset) raises lost and voids
    // the measurement in progress.
    function automatic void model_sample(bit v);
        bit r = v && !m_prev;
        bit f = !v && m_prev;
        tick_exp_t t;
        meas_exp_t m;
        m_prev = v;
        if (r) begin
            m_tcount = (m_tcount + 1) % 256;
            t.cyc = edge_n + SYNC_LAT; t.cnt = m_tcount;
            tick_q.push_back(t);
            if (m_have && (edge_n - m_rise) <= TIMEOUT) begin
                m.cyc = edge_n + SYNC_LAT; m.high = m_fall - m_rise; m.period = edge_n - m_rise;
                meas_q.push_back(m);
            end
            m_have = 1; m_rise = edge_n; m_ref = edge_n; m_lost_done = 0;
        end
        if (f) m_fall = edge_n;
        if (!m_lost_done && (edge_n - m_ref) == TIMEOUT) begin
            lost_q.push_back(edge_n + SYNC_LAT);
            m_lost_done = 1;
            m_have = 0;
        end
    endfunction

    initial begin : model_proc
        forever begin
            @(posedge clk);
            if (rst_n && armed) begin
                edge_n++;
                model_sample(pulse_in);
            end
        end
    end

    initial begin : monitor
        bit prev_lost = 0;
        meas_exp_t m;
        tick_exp_t t;
        forever begin
            @(negedge clk);
            if (!rst_n || !armed) begin
                prev_lost = 0;
                continue;
            end
            if (meas_valid) begin
                if (meas_q.size() == 0) check("meas_valid_unexpected", meas_valid, 0);
                else begin
                    m = meas_q.pop_front();
                    check("meas_edge", edge_n, m.cyc);
                    check("high_cnt", high_cnt, m.high);
                    check("period_cnt", period_cnt, m.period);
                    held_high = m.high; held_period = m.period;
                end
            end else if (meas_q.size() > 0 && meas_q[0].cyc <= edge_n) begin
                void'(meas_q.pop_front());
                check("meas_valid_missing", meas_valid, 1);
            end
            if (tick) begin
                tick_seen++;
                if (tick_q.size() == 0) check("tick_unexpected", tick, 0);
                else begin
                    t = tick_q.pop_front();
                    check("tick_edge", edge_n, t.cyc);
                    check("tick_count", tick_count, t.cnt);
                    check("lost_at_tick", lost, 0);
                    check("high_cnt_held", high_cnt, held_high);
                    check("period_cnt_held", period_cnt, held_period);
                end
            end else if (tick_q.size() > 0 && tick_q[0].cyc <= edge_n) begin
                void'(tick_q.pop_front());
                check("tick_missing", tick, 1);
            end
            if (lost && !prev_lost) begin
                if (lost_q.size() == 0) check("lost_unexpected", lost, 0);
                else check("lost_edge", edge_n, lost_q.pop_front());
            end else if (!lost && lost_q.size() > 0 && lost_q[0] <= edge_n) begin
                void'(lost_q.pop_front());
                check("lost_missing", lost, 1);
            end
            if (!lost && prev_lost) check("lost_cleared_by_tick", tick, 1);
            prev_lost = lost;
        end
    end

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_tick", tick, 0);
        check("rst_tick_count", tick_count, 0);
        check("rst_high_cnt", high_cnt, 0);
        check("rst_period_cnt", period_cnt, 0);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_lost", lost, 0);
        model_reset();
        repeat (cycles) @(negedge clk);
        #2 rst_n = 1'b1;
        armed = 1;
    endtask

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            @(negedge clk);
            pulse_in = v;
        end
    endtask

    task automatic wave(input int h, input int l, input int periods);
        for (int i = 0; i < periods; i++) begin
            drive(1'b1, h);
            drive(1'b0, l);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        do_reset(2);
        drive(1'b0, 3);
        wave(5, 7, 4);
        wave(3, 3, 3);
        drive(1'b1, 50);
        drive(1'b0, 5);
        wave(5, 7, 2);
        drive(1'b1, 2);
        do_reset(2);
        wave(5, 7, 3);
        pulse_in = 1'b0;
        do_reset(2);
        drive(1'b0, 2);
        wave(2, 2, 257);
        drive(1'b0, 4);
        check("wrap_tick_count", tick_count, 1);
        check("wrap_tick_seen", tick_seen, 257);
        wave(10, 30, 3);
        check("exact_timeout_lost", lost, 0);
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, $urandom_range(1, 30));
            drive(1'b0, $urandom_range(1, 45));
        end
        drive(1'b0, 50);
        drive(1'b0, 4);
        check("final_tick_count", tick_count, m_tcount);
        check("final_lost", lost, 1);
        check("tick_q_drained", tick_q.size(), 0);
        check("meas_q_drained", meas_q.size(), 0);
        check("lost_q_drained", lost_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
